// File: rtl/mod_addsub_pkg.sv
// Shared constants and state encoding for the word-serial modular adder/subtractor.
package mod_addsub_pkg;
    localparam int N     = 514;
    localparam int W     = 103;
    localparam int K     = (N + 1) / W;
    localparam int IDX_W = $clog2(K);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
endpackage

// File: rtl/mod_addsub_addc.sv
// word_addc: combinational W-bit adder with carry in/out, shared by both passes.
module word_addc
    import mod_addsub_pkg::*;
(
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
endmodule

// File: rtl/mod_addsub.sv
// Word-serial modular add/sub: raw pass then conditional correction pass against M.
// Optional MOD_ADDSUB_SKIP_EN: a borrow-free subtract skips the correction pass.
module mod_addsub
    import mod_addsub_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         subtract,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         busy,
    output logic         done
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);

    state_t                state;
    logic [K-1:0][W-1:0]   a_q, b_q, m_q, r_q, t_q;
    logic [IDX_W-1:0]      idx;
    logic                  sub_q, carry, c1, c2;
    logic [W-1:0]          x, y, sum;
    logic                  cout;
    logic [N-1:0]          sel;

    // Pass 1 forms a +/- b; pass 2 forms r - M (add) or r + M (sub).
    always_comb begin
        x = a_q[idx];
        y = b_q[idx] ^ {W{sub_q}};
        if (state == PASS2) begin
            x = r_q[idx];
            y = sub_q ? m_q[idx] : ~m_q[idx];
        end
    end

    word_addc u_addc (.x(x), .y(y), .cin(carry), .sum(sum), .cout(cout));

    always_comb begin
        if (sub_q) sel = N'(c1 ? r_q : t_q);
        else       sel = N'(c2 ? t_q : r_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            r_q    <= '0;
            t_q    <= '0;
            idx    <= '0;
            sub_q  <= 1'b0;
            carry  <= 1'b0;
            c1     <= 1'b0;
            c2     <= 1'b0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_q   <= {1'b0, in_a};
                    b_q   <= {1'b0, in_b};
                    m_q   <= {1'b0, in_m};
                    sub_q <= subtract;
                    carry <= subtract;
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= PASS1;
                end
                PASS1: begin
                    r_q[idx] <= sum;
                    carry    <= cout;
                    idx      <= idx + 1'b1;
                    if (idx == LAST) begin
                        c1    <= cout;
                        idx   <= '0;
                        carry <= ~sub_q;
                        state <= PASS2;
`ifdef MOD_ADDSUB_SKIP_EN
                        if (sub_q && cout) state <= DONE;
`endif
                    end
                end
                PASS2: begin
                    t_q[idx] <= sum;
                    carry    <= cout;
                    idx      <= idx + 1'b1;
                    if (idx == LAST) begin
                        c2    <= cout;
                        idx   <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    result <= sel;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_addsub.sv
// Scoreboarded random + directed bench for mod_addsub against a plain-arithmetic model.
module tb_mod_addsub;
    import mod_addsub_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         subtract = 1'b0;
    logic [N-1:0] in_a = '0, in_b = '0, in_m = '0;
    logic [N-1:0] result;
    logic         busy, done;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [N-1:0] exp_res[$];
    int           exp_lat[$];
    int           exp_acc[$];

    logic [N-1:0] va, vb, vm, ones;

    mod_addsub dut (
        .clk(clk), .reset(reset), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .result(result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] ref_mod(input logic [N-1:0] a, b, m, input bit sub);
        logic [N+1:0] s;
        if (!sub) begin
            s = {2'b0, a} + {2'b0, b};
            if (s >= {2'b0, m}) s = s - {2'b0, m};
        end else if (a >= b) begin
            s = {2'b0, a} - {2'b0, b};
        end else begin
            s = {2'b0, a} + {2'b0, m} - {2'b0, b};
        end
        return s[N-1:0];
    endfunction

    function automatic int ref_lat(input logic [N-1:0] a, b, input bit sub);
        int lat;
        lat = 2 * K + 1;
`ifdef MOD_ADDSUB_SKIP_EN
        if (sub && a >= b) lat = K + 1;
`endif
        return lat;
    endfunction

    function automatic logic [N-1:0] rand_wide();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < 17; i++) v = (v << 32) | N'($urandom);
        return v;
    endfunction

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (exp_res.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done at cycle %0d", cyc);
            end else begin
                check("result", result, exp_res.pop_front());
                check("latency", N'(cyc - exp_acc.pop_front()), N'(exp_lat.pop_front()));
                check("busy_at_done", N'(busy), N'(0));
            end
        end
    end

    task automatic issue(input logic [N-1:0] a, b, m, input bit sub);
        @(negedge clk);
        in_a = a; in_b = b; in_m = m; subtract = sub; start = 1'b1;
        @(posedge clk);
        #1;
        exp_res.push_back(ref_mod(a, b, m, sub));
        exp_lat.push_back(ref_lat(a, b, sub));
        exp_acc.push_back(cyc);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", N'(busy), N'(1));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && exp_res.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_res.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: pending=%0d expected 0", exp_res.size());
            exp_res.delete(); exp_lat.delete(); exp_acc.delete();
        end
    endtask

    task automatic op(input logic [N-1:0] a, b, m, input bit sub);
        issue(a, b, m, sub);
        wait_done();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_result", result, '0);
        check("reset_busy", N'(busy), N'(0));
        check("reset_done", N'(done), N'(0));
        reset = 1'b0;

        op(N'(1), N'(1), N'(5), 1'b0);
        op(N'(3), N'(4), N'(5), 1'b0);
        op(N'(1), N'(1), N'(5), 1'b1);
        op(N'(1), N'(3), N'(5), 1'b1);

        va = '0; va[102:0] = '1;
        vm = '0; vm[513] = 1'b1; vm[0] = 1'b1;
        op(va, N'(1), vm, 1'b0);
        check("word_carry_const", ref_mod(va, N'(1), vm, 1'b0), N'(1) << 103);
        ones = '1;
        va = ones - N'(1);
        op(va, va, ones, 1'b0);

        // Start while busy must be ignored: only one done with the first result.
        issue(N'(3), N'(4), N'(5), 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_a = N'(1); in_b = N'(3); subtract = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (3) @(posedge clk);

        // Reset during PASS1 discards the operation.
        issue(N'(3), N'(4), N'(7), 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; in_a = N'(2);
        @(negedge clk);
        start = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_res.delete(); exp_lat.delete(); exp_acc.delete();
        check("post_reset_busy", N'(busy), N'(0));
        check("post_reset_result", result, '0);
        check("post_reset_done", N'(done), N'(0));
        repeat (20) @(posedge clk);
        op(N'(1), N'(1), N'(5), 1'b0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) vm = N'($urandom_range(1, 20));
            else vm = rand_wide();
            if (vm == '0) vm = N'(1);
            va = rand_wide() % vm;
            vb = rand_wide() % vm;
            if ($urandom_range(0, 7) == 0) vb = va;
            op(va, vb, vm, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mod_addsub.md
# mod_addsub

Word-serial modular adder/subtractor for the Montgomery datapath. It sits directly downstream of the multi-precision add/subtract stage. It turns a raw 514-bit sum or difference into a fully reduced residue in [0, M) through a second, conditional correction pass against the modulus M. It has fixed latency by default, uses a start/done handshake, and each operation takes a single request.

## Interface
- N, 514, operand and modulus width in bits
- W, 103, datapath word width; (N+1) must be a multiple of W
- K, (N+1)/W = 5, derived word count per pass; not overridable
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- subtract  input  1  0: a+b mod M, 1: a-b mod M; captured with start
- in_a  input  N  operand a, precondition a < M
- in_b  input  N  operand b, precondition b < M
- in_m  input  N  modulus M, precondition M ≥ 1, captured with start
- result  output  N  reduced residue, held until the next accepted start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse, result valid

## Operation
- States: IDLE, PASS1, PASS2, DONE.
- IDLE + start:
  - capture a, b, M and subtract; zero-extend all three to N+1 bits
  - set word index 0 and carry = subtract
  - go to PASS1
- PASS1:
  - one word per cycle: r[i] = a[i] + (b[i] XOR {W{sub}}) + c
  - after word K-1, latch c1 = final carry
  - reset index; set carry = ~sub; go to PASS2
- PASS2:
  - one word per cycle over r
  - add: t = r + ~M + 1
  - sub: t = r + M
  - after word K-1, latch c2 = final carry; go to DONE
- Selection, registered on entry to DONE:
  - add: result = c2 ? t : r, because c2 = 1 means r ≥ M
  - sub: result = c1 ? r : t, because c1 = 0 means a borrow occurred
  - only the low N bits are kept; bit N of the selected value is always 0 when the preconditions hold
- DONE: done = 1 for exactly one cycle, then IDLE.
- start while busy or in DONE: ignored; no queuing.
- Preconditions violated: the output is unspecified but the timing is unchanged.
- reset at any time:
  - next state IDLE
  - busy = 0, done = 0, result = 0
  - internal r, t, carries and index cleared
  - any operation in flight is discarded with no done

## Timing
- Reset values: result = 0, busy = 0, done = 0.
- Accepting edge E0 (start high in IDLE):
  - PASS1 occupies edges E1..EK
  - PASS2 occupies edges EK+1..E2K
  - DONE is entered and result registered at E2K+1
  - done is high during the cycle following E2K+1
- Latency from the start edge to done high is 2K+1 = 11 cycles at the defaults.
- busy is high during the cycles following E0 through E2K, then low from the DONE cycle onward.
- Earliest next accepted start is the cycle after done; back-to-back throughput is one operation per 2K+2 cycles.
- result changes only at the DONE entry edge or on reset.

## Configuration
- MOD_ADDSUB_SKIP_EN
  - defined: a subtract with c1 = 1 (no borrow) skips PASS2 and selects r directly. Latency for that case is K+1 = 6 cycles; all other cases stay at 2K+1.
  - undefined: every operation runs both passes with a fixed latency of 2K+1.

## Structure
- Package mod_addsub_pkg holds:
  - N, W, K constants
  - the state enum (IDLE, PASS1, PASS2, DONE)
  - the word-index width $clog2(K)
- One sub-module, word_addc: a combinational W-bit adder with carry-in and carry-out, shared by both passes. The top level contains the FSM, word registers, carry flop and output mux.

## Test plan
- add a=1, b=1, M=5 → result 2, done pulse exactly 11 cycles after start, busy low afterwards.
- add a=3, b=4, M=5 → result 2, exercising the correction pass.
- sub a=1, b=1, M=5 → result 0; with MOD_ADDSUB_SKIP_EN, done arrives at 6 cycles instead of 11.
- sub a=1, b=3, M=5 → result 3, the borrow path with M added back.
- Word-boundary and width checks:
  - add a=2^103−1, b=1, M=2^513+1 → result 2^103, carry crosses the word boundary
  - add a=b=2^514−2, M=2^514−1 → result 2^514−3, exercising bit N of the intermediate
- Reset pulse during PASS1, with a second start pulsed while busy:
  - the start while busy is ignored
  - after reset: busy = 0, result = 0, no done pulse
  - a following add 1+1 mod 5 → 2 with normal 11-cycle latency
